univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register. Successor to the fixed 4-stage serial-in/serial-out register.
- Adds configurable width, four operating modes (hold, shift right, shift left, parallel load), and serial in/out at both ends.
- Tracks a saturating shift count with a full flag and a one-cycle done pulse.
- Used as the serialiser/deserialiser and general-purpose delay element in datapaths.

Parameters:
- WIDTH, 8, number of register stages. Legal range is WIDTH >= 2.
- RESET_VAL, 0, WIDTH-bit value loaded into q on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  operation enable. When 0, the register holds regardless of mode.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input for shift right; enters q[WIDTH-1].
- sin_l  input  1  serial input for shift left; enters q[0].
- pdata  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0]; this is the bit leaving on shift right.
- sout_l  output  1  equals q[WIDTH-1]; this is the bit leaving on shift left.
- shift_cnt  output  $clog2(WIDTH+1)  shifts performed since the last load or reset; saturates at WIDTH.
- full  output  1  high while shift_cnt == WIDTH.
- done  output  1  one-cycle pulse on the edge where shift_cnt goes from WIDTH-1 to WIDTH.

Behaviour:
- All registers update on the posedge of clk. No asynchronous paths. sout_r, sout_l and full are purely combinational from registered state.
- Reset (rst=1 at an edge):
  - q <= RESET_VAL; shift_cnt <= 0; done <= 0.
  - Reset has priority over en and mode.
  - Reset mid-shift discards the shift in progress; the count restarts from 0.
- en=0: q and shift_cnt hold; done <= 0.
- en=1, mode 00 (hold): q and shift_cnt hold; done <= 0.
- en=1, mode 01 (shift right):
  - q <= {sin_r, q[WIDTH-1:1]}.
  - shift_cnt <= min(shift_cnt+1, WIDTH).
- en=1, mode 10 (shift left):
  - q <= {q[WIDTH-2:0], sin_l}.
  - shift_cnt increments and saturates exactly as for shift right.
- en=1, mode 11 (parallel load): q <= pdata; shift_cnt <= 0; done <= 0.
- Mixed directions: shift left and shift right both advance the same counter. Direction changes do not reset the count.
- Saturation: once shift_cnt == WIDTH, further shifts keep it at WIDTH, keep full=1, and do not re-pulse done.
- done: registered. It is 1 for exactly the cycle after the edge on which shift_cnt becomes WIDTH, and 0 otherwise.
- Latency:
  - A bit presented on sin_r appears on sout_r after exactly WIDTH enabled shift-right edges.
  - The same holds for sin_l to sout_l under shift left.
  - For WIDTH=4 this reproduces the original 4-stage SISO timing.
- Parallel-to-serial use: load, then shift right; the LSB-first stream appears on sout_r. done marks the edge on which the last original bit (pdata[WIDTH-1]) has been shifted out.
- Serial-to-parallel use: shift right WIDTH times; q then holds the word with the first received bit in q[0]. full indicates the word is complete.
- No X propagation from unused inputs: sin_l is ignored in mode 01, sin_r is ignored in mode 10, and pdata is ignored in modes other than 11.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 for 1 cycle with en=1, mode=11 → q=8'hA5, shift_cnt=0, full=0, done=0. Reset wins over the load.
- Parallel load then shift out: load pdata=8'hB4, then 8 shift-right cycles with sin_r=0 → sout_r sequence is 0,0,1,0,1,1,0,1. q=8'h00 afterwards. done pulses once after the 8th shift. full=1.
- Serial in (WIDTH=4): shift right with sin_r = 1,0,1,1 → q=4'b1101, sout_r=1 on the 4th cycle after first input. Shift left 4 times with sin_l = 1,1,0,0 from q=0 → q=4'b1100.
- Saturation/hold: after full, 3 more shifts → shift_cnt stays at WIDTH and done stays 0. en=0 or mode=00 with toggling sin → q unchanged.
- Reset mid-operation: after 5 of 8 shifts assert rst → q=RESET_VAL, shift_cnt=0. The next 8 shifts produce exactly one done pulse.
- Load mid-shift: after 3 shifts load pdata=8'h0F → shift_cnt=0, q=8'h0F, no done pulse until 8 further shifts.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register with hold,
// shift right, shift left and parallel load, plus a saturating shift count.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en, mode      enable; 00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r, sin_l  serial inputs entering q[WIDTH-1] / q[0]
//   pdata         parallel load word
//   q             register contents
//   sout_r/sout_l bits leaving on shift right (q[0]) / shift left (q[MSB])
//   shift_cnt     shifts since last load/reset, saturating at WIDTH
//   full, done    count at WIDTH; one-cycle pulse when it gets there
module univ_shift_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pdata,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       full,
  output logic                       done
);

  localparam int unsigned     CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);
  localparam logic [1:0]      M_HOLD  = 2'b00;
  localparam logic [1:0]      M_SHR   = 2'b01;
  localparam logic [1:0]      M_SHL   = 2'b10;
  localparam logic [1:0]      M_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             shifting;

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    shifting = 1'b0;
    if (en) begin
      unique case (mode)
        M_HOLD: q_nxt = q;
        M_SHR: begin
          q_nxt    = {sin_r, q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        M_SHL: begin
          q_nxt    = {q[WIDTH-2:0], sin_l};
          shifting = 1'b1;
        end
        M_LOAD: begin
          q_nxt   = pdata;
          cnt_nxt = '0;
        end
      endcase
    end
    // Both directions share one counter; done fires only on the
    // WIDTH-1 -> WIDTH step, so a saturated count never re-pulses.
    if (shifting && (shift_cnt != CNT_MAX)) begin
      cnt_nxt  = shift_cnt + CW'(1);
      done_nxt = (shift_cnt == CNT_MAX - CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      q         <= q_nxt;
      shift_cnt <= cnt_nxt;
      done      <= done_nxt;
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign full   = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scenario tasks for univ_shift_reg at WIDTH=8
// (RESET_VAL=8'hA5) and WIDTH=4, with a queue of expected serial bits.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, en8, sr8, sl8;
  logic [1:0] mode8;
  logic [7:0] pd8, q8;
  logic       so_r8, so_l8, full8, done8;
  logic [3:0] cnt8;

  logic       rst4, en4, sr4, sl4;
  logic [1:0] mode4;
  logic [3:0] pd4, q4;
  logic       so_r4, so_l4, full4, done4;
  logic [2:0] cnt4;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8),
    .sin_r(sr8), .sin_l(sl8), .pdata(pd8), .q(q8),
    .sout_r(so_r8), .sout_l(so_l8), .shift_cnt(cnt8),
    .full(full8), .done(done8)
  );

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .mode(mode4),
    .sin_r(sr4), .sin_l(sl4), .pdata(pd4), .q(q4),
    .sout_r(so_r4), .sout_l(so_l4), .shift_cnt(cnt4),
    .full(full4), .done(done4)
  );

  int  n_run  = 0;
  int  n_fail = 0;
  bit  exp_q[$];
  bit  e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst8 = 1; en8 = 1; mode8 = 2'b11; pd8 = 8'hFF;
    rst4 = 1; en4 = 1; mode4 = 2'b11; pd4 = 4'hF;
    tick();
    rst8 = 0; rst4 = 0; en8 = 0; en4 = 0;
    n_run++;
    if (q8 !== 8'hA5 || cnt8 !== 4'd0 || full8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: q=%h cnt=%0d full=%b done=%b, want a5 0 0 0",
               q8, cnt8, full8, done8);
    end
    n_run++;
    if (q4 !== 4'h0 || cnt4 !== 3'd0 || full4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: q=%h cnt=%0d full=%b done=%b, want 0 0 0 0",
               q4, cnt4, full4, done4);
    end
  endtask

  task automatic test_load_shift_out();
    int pulses = 0;
    en8 = 1; mode8 = 2'b11; pd8 = 8'hB4;
    tick();
    n_run++;
    if (q8 !== 8'hB4 || cnt8 !== 4'd0) begin
      n_fail++;
      $display("FAIL load: q=%h cnt=%0d, want b4 0", q8, cnt8);
    end
    exp_q = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    mode8 = 2'b01; sr8 = 0; sl8 = 1; pd8 = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_run++;
      if (so_r8 !== e) begin
        n_fail++;
        $display("FAIL p2s bit%0d: sout_r=%b, want %b", i, so_r8, e);
      end
      tick();
      if (done8 === 1'b1) pulses++;
      n_run++;
      if (done8 !== (i == 7)) begin
        n_fail++;
        $display("FAIL p2s done%0d: done=%b, want %b", i, done8, (i == 7));
      end
    end
    n_run++;
    if (q8 !== 8'h00 || cnt8 !== 4'd8 || full8 !== 1'b1 || pulses != 1) begin
      n_fail++;
      $display("FAIL p2s end: q=%h cnt=%0d full=%b pulses=%0d, want 00 8 1 1",
               q8, cnt8, full8, pulses);
    end
  endtask

  task automatic test_serial_in();
    bit [3:0] sr_bits = 4'b1101;
    bit [3:0] sl_bits = 4'b0011;
    en4 = 1; mode4 = 2'b01; pd4 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      sr4 = sr_bits[i]; sl4 = ~sr_bits[i];
      exp_q.push_back(i == 3);
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (so_r4 !== e || done4 !== (i == 3)) begin
        n_fail++;
        $display("FAIL s2p r%0d: sout_r=%b done=%b, want %b %b",
                 i, so_r4, done4, e, (i == 3));
      end
    end
    n_run++;
    if (q4 !== 4'b1101 || full4 !== 1'b1 || cnt4 !== 3'd4) begin
      n_fail++;
      $display("FAIL s2p word: q=%b full=%b cnt=%0d, want 1101 1 4",
               q4, full4, cnt4);
    end
    rst4 = 1;
    tick();
    rst4 = 0; mode4 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sl4 = sl_bits[i]; sr4 = ~sl_bits[i];
      exp_q.push_back(i == 3);
      tick();
      e = exp_q.pop_front();
      n_run++;
      if (so_l4 !== e) begin
        n_fail++;
        $display("FAIL shl l%0d: sout_l=%b, want %b", i, so_l4, e);
      end
    end
    n_run++;
    if (q4 !== 4'b1100 || cnt4 !== 3'd4 || done4 !== 1'b1) begin
      n_fail++;
      $display("FAIL shl word: q=%b cnt=%0d done=%b, want 1100 4 1",
               q4, cnt4, done4);
    end
    en4 = 0;
  endtask

  task automatic test_saturation_hold();
    en8 = 1; mode8 = 2'b01; sr8 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if (cnt8 !== 4'd8 || done8 !== 1'b0 || full8 !== 1'b1) begin
        n_fail++;
        $display("FAIL sat%0d: cnt=%0d done=%b full=%b, want 8 0 1",
                 i, cnt8, done8, full8);
      end
    end
    n_run++;
    if (q8 !== 8'hE0) begin
      n_fail++;
      $display("FAIL sat q: q=%h, want e0", q8);
    end
    for (int i = 0; i < 8; i++) begin
      en8 = (i >= 4);
      mode8 = (i >= 4) ? 2'b00 : 2'($urandom_range(0, 3));
      sr8 = i[0]; sl8 = ~i[0]; pd8 = 8'($urandom);
      tick();
      n_run++;
      if (q8 !== 8'hE0 || cnt8 !== 4'd8 || done8 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d: q=%h cnt=%0d done=%b, want e0 8 0",
                 i, q8, cnt8, done8);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    en8 = 1; mode8 = 2'b11; pd8 = 8'h3C;
    tick();
    mode8 = 2'b01; sr8 = 0;
    repeat (5) tick();
    n_run++;
    if (cnt8 !== 4'd5 || q8 !== 8'h01) begin
      n_fail++;
      $display("FAIL mid5: cnt=%0d q=%h, want 5 01", cnt8, q8);
    end
    rst8 = 1;
    tick();
    rst8 = 0;
    n_run++;
    if (q8 !== 8'hA5 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst mid: q=%h cnt=%0d done=%b, want a5 0 0",
               q8, cnt8, done8);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done8 === 1'b1) pulses++;
      n_run++;
      if (cnt8 !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL rst cnt%0d: cnt=%0d, want %0d", i, cnt8, i + 1);
      end
    end
    n_run++;
    if (pulses != 1 || done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst done: pulses=%0d last=%b, want 1 1", pulses, done8);
    end
  endtask

  task automatic test_load_mid();
    int pulses = 0;
    en8 = 1; mode8 = 2'b11; pd8 = 8'hC3;
    tick();
    mode8 = 2'b01; sr8 = 1;
    repeat (3) tick();
    mode8 = 2'b11; pd8 = 8'h0F;
    tick();
    n_run++;
    if (q8 !== 8'h0F || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL load mid: q=%h cnt=%0d done=%b, want 0f 0 0",
               q8, cnt8, done8);
    end
    mode8 = 2'b01; sr8 = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(i < 4);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_run++;
      if (so_r8 !== e) begin
        n_fail++;
        $display("FAIL lm bit%0d: sout_r=%b, want %b", i, so_r8, e);
      end
      tick();
      if (done8 === 1'b1) pulses++;
    end
    n_run++;
    if (pulses != 1 || done8 !== 1'b1 || q8 !== 8'h00) begin
      n_fail++;
      $display("FAIL lm end: pulses=%0d done=%b q=%h, want 1 1 00",
               pulses, done8, q8);
    end
  endtask

  task automatic test_back_to_back();
    en8 = 1; mode8 = 2'b11; pd8 = 8'h81;
    tick();
    mode8 = 2'b10; sl8 = 0; sr8 = 1;
    repeat (4) tick();
    n_run++;
    if (q8 !== 8'h10 || cnt8 !== 4'd4 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mix left: q=%h cnt=%0d done=%b, want 10 4 0",
               q8, cnt8, done8);
    end
    mode8 = 2'b01; sl8 = 0; sr8 = 1;
    repeat (3) tick();
    n_run++;
    if (cnt8 !== 4'd7 || done8 !== 1'b0 || full8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mix 7: cnt=%0d done=%b full=%b, want 7 0 0",
               cnt8, done8, full8);
    end
    tick();
    n_run++;
    if (q8 !== 8'hF1 || cnt8 !== 4'd8 || done8 !== 1'b1 || full8 !== 1'b1) begin
      n_fail++;
      $display("FAIL mix end: q=%h cnt=%0d done=%b full=%b, want f1 8 1 1",
               q8, cnt8, done8, full8);
    end
    en8 = 0;
    tick();
    n_run++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mix pulse: done=%b, want 0", done8);
    end
  endtask

  initial begin
    rst8 = 0; en8 = 0; mode8 = 0; sr8 = 0; sl8 = 0; pd8 = 0;
    rst4 = 0; en4 = 0; mode4 = 0; sr4 = 0; sl4 = 0; pd4 = 0;
    #2;
    test_reset();
    test_load_shift_out();
    test_serial_in();
    test_saturation_hold();
    test_reset_mid();
    test_load_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, want finish before 100000");
    $fatal(1);
  end

endmodule
